// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: internal oversample tick, two-flop rxd synchroniser,
// mid-bit sampling, optional parity and one or two stop bits with error flags.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 326,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic                 tick,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rxd_done,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int DW = $clog2(BAUD_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_HALF    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state,   w_stateNext;
    logic [DW-1:0]        r_divCnt;
    logic                 r_sync1,   r_sync2;
    logic                 w_rxdS;
    logic                 w_tick;
    logic [SW-1:0]        r_sCnt,    w_sCntNext;
    logic [NW-1:0]        r_n,       w_nNext;
    logic                 r_stopCnt, w_stopCntNext;
    logic [DATA_BITS-1:0] r_shreg,   w_shregNext;
    logic                 r_parBit,  w_parBitNext;
    logic                 r_ferr,    w_ferrNext;
    logic                 r_armed,   w_armedNext;
    logic                 w_finish;
    logic                 w_parExp;
    logic [DATA_BITS-1:0] r_dataOut;
    logic                 r_done,    r_parErr,  r_frameErr;

    assign w_rxdS = r_sync2;
    assign w_tick = (r_divCnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_divCnt <= '0;
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
        end else begin
            r_divCnt <= w_tick ? '0 : r_divCnt + 1'b1;
            r_sync1  <= rxd;
            r_sync2  <= r_sync1;
        end
    end

    // r_armed blocks a new start until the line has been seen high after a completion,
    // so a held-low break produces exactly one errored frame.
    always_comb begin
        w_stateNext   = r_state;
        w_sCntNext    = r_sCnt;
        w_nNext       = r_n;
        w_stopCntNext = r_stopCnt;
        w_shregNext   = r_shreg;
        w_parBitNext  = r_parBit;
        w_ferrNext    = r_ferr;
        w_armedNext   = r_armed | w_rxdS;
        w_finish      = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxdS && r_armed) begin
                        w_stateNext = S_START;
                        w_sCntNext  = '0;
                        w_ferrNext  = 1'b0;
                    end
                end
                S_START: begin
                    if (r_sCnt == S_HALF) begin
                        if (!w_rxdS) begin
                            w_stateNext = S_DATA;
                            w_sCntNext  = '0;
                            w_nNext     = '0;
                        end else begin
                            w_stateNext = S_IDLE;
                        end
                    end else begin
                        w_sCntNext = r_sCnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_sCnt == S_LAST) begin
                        w_shregNext = {w_rxdS, r_shreg[DATA_BITS-1:1]};
                        w_sCntNext  = '0;
                        if (r_n == N_LAST) begin
                            w_stateNext   = (PARITY != 0) ? S_PARITY : S_STOP;
                            w_stopCntNext = 1'b0;
                        end else begin
                            w_nNext = r_n + 1'b1;
                        end
                    end else begin
                        w_sCntNext = r_sCnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_sCnt == S_LAST) begin
                        w_parBitNext  = w_rxdS;
                        w_sCntNext    = '0;
                        w_stopCntNext = 1'b0;
                        w_stateNext   = S_STOP;
                    end else begin
                        w_sCntNext = r_sCnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_sCnt == S_LAST) begin
                        w_sCntNext = '0;
                        if (!w_rxdS) begin
                            w_ferrNext = 1'b1;
                        end
                        if (r_stopCnt == STOP_LAST) begin
                            w_stateNext = S_IDLE;
                            w_finish    = 1'b1;
                            w_armedNext = w_rxdS;
                        end else begin
                            w_stopCntNext = r_stopCnt + 1'b1;
                        end
                    end else begin
                        w_sCntNext = r_sCnt + 1'b1;
                    end
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_sCnt    <= '0;
            r_n       <= '0;
            r_stopCnt <= 1'b0;
            r_shreg   <= '0;
            r_parBit  <= 1'b0;
            r_ferr    <= 1'b0;
            r_armed   <= 1'b1;
        end else begin
            r_state   <= w_stateNext;
            r_sCnt    <= w_sCntNext;
            r_n       <= w_nNext;
            r_stopCnt <= w_stopCntNext;
            r_shreg   <= w_shregNext;
            r_parBit  <= w_parBitNext;
            r_ferr    <= w_ferrNext;
            r_armed   <= w_armedNext;
        end
    end

    assign w_parExp = (PARITY == 2) ? ~(^r_shreg) : (^r_shreg);

    // Completion outputs land one cycle after the final stop-sample tick and hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done     <= 1'b0;
            r_dataOut  <= '0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_dataOut  <= r_shreg;
                r_frameErr <= w_ferrNext;
                r_parErr   <= (PARITY != 0) && (r_parBit != w_parExp);
            end
        end
    end

    assign tick       = w_tick;
    assign busy       = (r_state != S_IDLE);
    assign data_out   = r_dataOut;
    assign rxd_done   = r_done;
    assign parity_err = r_parErr;
    assign frame_err  = r_frameErr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 8E1, 9O2) share clock and reset;
// expected frames are queued when driven and checked when each receiver pulses rxd_done.
module tb_uart_rx_cfg;

    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxdA, rxdB, rxdC;
    logic       tickA, tickB, tickC;
    logic       busyA, busyB, busyC;
    logic [7:0] dataA, dataB;
    logic [8:0] dataC;
    logic       doneA, doneB, doneC;
    logic       perrA, perrB, perrC;
    logic       ferrA, ferrB, ferrC;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];
    exp_t eA, eB, eC;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) dutA (
        .clk(clk), .rst(rst), .rxd(rxdA), .tick(tickA), .busy(busyA), .data_out(dataA),
        .rxd_done(doneA), .parity_err(perrA), .frame_err(ferrA)
    );

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) dutB (
        .clk(clk), .rst(rst), .rxd(rxdB), .tick(tickB), .busy(busyB), .data_out(dataB),
        .rxd_done(doneB), .parity_err(perrB), .frame_err(ferrB)
    );

    uart_rx_cfg #(.DATA_BITS(9), .OVERSAMPLE(16), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(2)) dutC (
        .clk(clk), .rst(rst), .rxd(rxdC), .tick(tickC), .busy(busyC), .data_out(dataC),
        .rxd_done(doneC), .parity_err(perrC), .frame_err(ferrC)
    );

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setLine(input int which, input logic v);
        case (which)
            0:       rxdA = v;
            1:       rxdB = v;
            default: rxdC = v;
        endcase
    endtask

    task automatic driveBit(input int which, input logic v);
        setLine(which, v);
        waitClks(BIT_CLKS);
    endtask

    function automatic int qSize(input int which);
        case (which)
            0:       return qA.size();
            1:       return qB.size();
            default: return qC.size();
        endcase
    endfunction

    // Queue the expected result, then drive start, data (LSB first), parity, stops, one idle bit.
    task automatic applyStimulus(input int which, input logic [8:0] data, input int nData,
                                 input bit hasPar, input logic parBit, input logic stop1,
                                 input logic stop2, input int nStops, input exp_t e);
        case (which)
            0:       qA.push_back(e);
            1:       qB.push_back(e);
            default: qC.push_back(e);
        endcase
        driveBit(which, 1'b0);
        for (int i = 0; i < nData; i++) driveBit(which, data[i]);
        if (hasPar) driveBit(which, parBit);
        driveBit(which, stop1);
        if (nStops == 2) driveBit(which, stop2);
        driveBit(which, 1'b1);
    endtask

    task automatic waitDrain(input string tag, input int which);
        for (int i = 0; i < 400; i++) begin
            if (qSize(which) == 0) break;
            @(negedge clk);
        end
        checkOutput(tag, 16'(qSize(which)), 16'd0);
    endtask

    // Scoreboard monitors: every rxd_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (doneA === 1'b1) begin
            checkOutput("A_doneExpected", 16'(qA.size() != 0), 16'd1);
            if (qA.size() != 0) begin
                eA = qA.pop_front();
                checkOutput("A_data", 16'(dataA), 16'(eA.data));
                checkOutput("A_parityErr", 16'(perrA), 16'(eA.perr));
                checkOutput("A_frameErr", 16'(ferrA), 16'(eA.ferr));
                checkOutput("A_busyAtDone", 16'(busyA), 16'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (doneB === 1'b1) begin
            checkOutput("B_doneExpected", 16'(qB.size() != 0), 16'd1);
            if (qB.size() != 0) begin
                eB = qB.pop_front();
                checkOutput("B_data", 16'(dataB), 16'(eB.data));
                checkOutput("B_parityErr", 16'(perrB), 16'(eB.perr));
                checkOutput("B_frameErr", 16'(ferrB), 16'(eB.ferr));
            end
        end
    end

    always @(negedge clk) begin
        if (doneC === 1'b1) begin
            checkOutput("C_doneExpected", 16'(qC.size() != 0), 16'd1);
            if (qC.size() != 0) begin
                eC = qC.pop_front();
                checkOutput("C_data", 16'(dataC), 16'(eC.data));
                checkOutput("C_parityErr", 16'(perrC), 16'(eC.perr));
                checkOutput("C_frameErr", 16'(ferrC), 16'(eC.ferr));
            end
        end
    end

    initial begin
        int ticks;
        rst  = 1'b0;
        rxdA = 1'b1;
        rxdB = 1'b1;
        rxdC = 1'b1;
        waitClks(5);

        // Reset state
        checkOutput("rst_tick", 16'(tickA), 16'd0);
        checkOutput("rst_busy", 16'(busyA), 16'd0);
        checkOutput("rst_done", 16'(doneA), 16'd0);
        checkOutput("rst_parityErr", 16'(perrA), 16'd0);
        checkOutput("rst_frameErr", 16'(ferrA), 16'd0);
        checkOutput("rst_data", 16'(dataA), 16'd0);
        checkOutput("rst_dataC", 16'(dataC), 16'd0);
        rst = 1'b1;
        waitClks(3);

        // Tick rate: one strobe every BAUD_DIV=4 clocks
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ticks += int'(tickA);
        end
        checkOutput("tick_count40", 16'(ticks), 16'd10);

        // 8N1 0x55
        applyStimulus(0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, '{9'h055, 1'b0, 1'b0});
        waitDrain("A_0x55_drain", 0);
        checkOutput("A_busyIdle", 16'(busyA), 16'd0);

        // Even parity 0xA3: correct parity bit 0, then wrong parity bit 1
        applyStimulus(1, 9'h0A3, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, '{9'h0A3, 1'b0, 1'b0});
        waitDrain("B_goodParity_drain", 1);
        applyStimulus(1, 9'h0A3, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, '{9'h0A3, 1'b1, 1'b0});
        waitDrain("B_badParity_drain", 1);

        // Framing error on 0x3C, then a clean 0x81 clears it
        applyStimulus(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1, '{9'h03C, 1'b0, 1'b1});
        waitDrain("A_0x3C_drain", 0);
        applyStimulus(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, '{9'h081, 1'b0, 1'b0});
        waitDrain("A_0x81_drain", 0);

        // Short glitch (5 ticks) is rejected as a false start
        setLine(0, 1'b0);
        waitClks(10);
        checkOutput("glitch_busyHigh", 16'(busyA), 16'd1);
        waitClks(10);
        setLine(0, 1'b1);
        waitClks(60);
        checkOutput("glitch_busyLow", 16'(busyA), 16'd0);
        waitClks(BIT_CLKS * 12);
        checkOutput("glitch_noFrame", 16'(qSize(0)), 16'd0);
        checkOutput("glitch_dataHeld", 16'(dataA), 16'h81);
        checkOutput("glitch_frameErrHeld", 16'(ferrA), 16'd0);

        // Reset in the middle of data bit 4 of 0xF0 discards the frame
        driveBit(0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(0, 1'b0);
        setLine(0, 1'b1);
        waitClks(BIT_CLKS / 2);
        rst = 1'b0;
        #1;
        checkOutput("midReset_busy", 16'(busyA), 16'd0);
        checkOutput("midReset_data", 16'(dataA), 16'd0);
        waitClks(3);
        rst = 1'b1;
        waitClks(BIT_CLKS * 6);
        checkOutput("midReset_noDone", 16'(qSize(0)), 16'd0);
        checkOutput("midReset_busyAfter", 16'(busyA), 16'd0);
        applyStimulus(0, 9'h00F, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, '{9'h00F, 1'b0, 1'b0});
        waitDrain("A_0x0F_drain", 0);

        // 9 data bits, odd parity, two stops with the second low
        applyStimulus(2, 9'h1A5, 9, 1'b1, 1'b0, 1'b1, 1'b0, 2, '{9'h1A5, 1'b0, 1'b1});
        waitDrain("C_0x1A5_drain", 2);

        // Break: one errored all-zero frame, then stay idle while the line is low
        qA.push_back('{9'h000, 1'b0, 1'b1});
        setLine(0, 1'b0);
        waitClks(BIT_CLKS * 14);
        checkOutput("break_idleWhileLow", 16'(busyA), 16'd0);
        setLine(0, 1'b1);
        waitDrain("break_drain", 0);
        waitClks(BIT_CLKS * 2);
        checkOutput("break_busyAfterRelease", 16'(busyA), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
